// File: rtl/axi_rab_pkg.sv
// Shared definitions for the RAB AXI4 channel buffers.
// Holds the RRESP encodings, the R-entry field offsets and the entry-width helper.
// R entry layout (LSB first): rlast, rdata, rresp, rid, ruser.
package axi_rab_pkg;

    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rresp_e;

    localparam int unsigned RESP_W   = 2;
    localparam int unsigned LAST_LSB = 0;
    localparam int unsigned DATA_LSB = 1;

    // Offsets of the fields that sit above the data-width-dependent rdata field
    function automatic int unsigned resp_lsb(input int unsigned data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned data_w);
        return resp_lsb(data_w) + RESP_W;
    endfunction

    function automatic int unsigned user_lsb(input int unsigned data_w, input int unsigned id_w);
        return id_lsb(data_w) + id_w;
    endfunction

    // W = DATA + ID + USER + rresp(2) + rlast(1)
    function automatic int unsigned r_entry_width(input int unsigned data_w,
                                                  input int unsigned id_w,
                                                  input int unsigned user_w);
        return data_w + id_w + user_w + 3;
    endfunction

endpackage

// File: rtl/axi4_rdch_buffer_if.sv
// AXI4 read-data (R) channel bundle.
// master modport: the side that receives beats and drives rready.
// slave  modport: the side that drives rvalid and the beat payload.
interface axi4_rdch_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned USER_W = 2
);
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;
    logic [USER_W-1:0] ruser;

    modport master (
        input  rvalid, rdata, rid, rresp, rlast, ruser,
        output rready
    );

    modport slave (
        output rvalid, rdata, rid, rresp, rlast, ruser,
        input  rready
    );
endinterface

// File: rtl/axi4_rdch_fifo.sv
// Generic W-bit, DEPTH-entry synchronous FIFO with a registered not-full ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data push side;
// out_valid_c/out_ready/out_data_c pop side (head entry, derived from flops);
// count = registered occupancy 0..DEPTH.
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module axi4_rdch_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid_c,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data_c,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             rdy_q, rdy_d;
    logic [W-1:0]     mem_q [DEPTH];

    logic empty_c, full_c, push_c, pop_c;

    // Pointer/count/ready next-state
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        // rdy_q is already low when full; the full term only guards the pointers
        push_c   = in_valid & rdy_q & ~full_c;
        pop_c    = ~empty_c & out_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + PTR_W'(push_c) - PTR_W'(pop_c);
        // Registered ready looks at the post-edge occupancy, never at out_ready directly
        rdy_d    = (count_d < PTR_W'(DEPTH));
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage: entries are not reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= in_data;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid_c = ~empty_c;
    assign out_data_c  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count       = count_q;

endmodule

// File: rtl/axi4_rdch_buffer.sv
// Elastic buffer for the AXI4 R channel: beats arriving on m_axi4 (from the
// downstream slave) are queued and presented on s_axi4 (to the upstream master)
// with no combinational path between the two sides.
// Ports: axi4_aclk, axi4_arstn (async active-low); m_axi4 (master modport,
// receives beats, drives rready); s_axi4 (slave modport, drives head beat);
// rd_fill_level (occupancy, present only with AXI4_RDCH_BUF_LEVEL_EN defined).
module axi4_rdch_buffer
    import axi_rab_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ID_WIDTH   = 4,
    parameter int unsigned C_AXI_USER_WIDTH = 2,
    parameter int unsigned DEPTH            = 2
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    axi4_rdch_buffer_if.master          m_axi4,
    axi4_rdch_buffer_if.slave           s_axi4
`ifdef AXI4_RDCH_BUF_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]      rd_fill_level
`endif
);
    localparam int unsigned W        = r_entry_width(C_AXI_DATA_WIDTH, C_AXI_ID_WIDTH,
                                                     C_AXI_USER_WIDTH);
    localparam int unsigned RESP_LSB = resp_lsb(C_AXI_DATA_WIDTH);
    localparam int unsigned ID_LSB   = id_lsb(C_AXI_DATA_WIDTH);
    localparam int unsigned USER_LSB = user_lsb(C_AXI_DATA_WIDTH, C_AXI_ID_WIDTH);

    logic [W-1:0]              push_data;
    logic [W-1:0]              head_data_c;
    logic [$clog2(DEPTH):0]    fill_level;

    // Pack incoming beat
    assign push_data = {m_axi4.ruser, m_axi4.rid, m_axi4.rresp, m_axi4.rdata, m_axi4.rlast};

    axi4_rdch_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (axi4_aclk),
        .rst_n       (axi4_arstn),
        .in_valid    (m_axi4.rvalid),
        .in_ready    (m_axi4.rready),
        .in_data     (push_data),
        .out_valid_c (s_axi4.rvalid),
        .out_ready   (s_axi4.rready),
        .out_data_c  (head_data_c),
        .count       (fill_level)
    );

    // Unpack head entry
    assign s_axi4.rlast = head_data_c[LAST_LSB];
    assign s_axi4.rdata = head_data_c[DATA_LSB +: C_AXI_DATA_WIDTH];
    assign s_axi4.rresp = head_data_c[RESP_LSB +: RESP_W];
    assign s_axi4.rid   = head_data_c[ID_LSB   +: C_AXI_ID_WIDTH];
    assign s_axi4.ruser = head_data_c[USER_LSB +: C_AXI_USER_WIDTH];

`ifdef AXI4_RDCH_BUF_LEVEL_EN
    assign rd_fill_level = fill_level;
`else
    // Occupancy still drives ready internally; only the port is dropped
    logic unused_fill_level;
    assign unused_fill_level = ^fill_level;
`endif

endmodule

// File: tb/tb_axi4_rdch_buffer.sv
// Directed bench for axi4_rdch_buffer (DEPTH = 2, default widths).
// Inputs change at the falling edge, outputs are sampled at the falling edge
// before the next stimulus is applied.
module tb_axi4_rdch_buffer;
    import axi_rab_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 2;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    axi4_rdch_buffer_if #(.DATA_W(DW), .ID_W(IW), .USER_W(UW)) m_if ();
    axi4_rdch_buffer_if #(.DATA_W(DW), .ID_W(IW), .USER_W(UW)) s_if ();
`ifdef AXI4_RDCH_BUF_LEVEL_EN
    logic [$clog2(DEPTH):0] rd_fill_level;
`endif

    axi4_rdch_buffer #(
        .C_AXI_DATA_WIDTH (DW),
        .C_AXI_ID_WIDTH   (IW),
        .C_AXI_USER_WIDTH (UW),
        .DEPTH            (DEPTH)
    ) dut (
        .axi4_aclk     (clk),
        .axi4_arstn    (rst_n),
        .m_axi4        (m_if),
        .s_axi4        (s_if)
`ifdef AXI4_RDCH_BUF_LEVEL_EN
        ,
        .rd_fill_level (rd_fill_level)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] d, input logic [3:0] id,
                       input logic [1:0] resp, input logic last, input logic [1:0] user);
        m_if.rvalid = v;
        m_if.rdata  = d;
        m_if.rid    = id;
        m_if.rresp  = resp;
        m_if.rlast  = last;
        m_if.ruser  = user;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] d, input logic [3:0] id,
                            input logic [1:0] resp, input logic last, input logic [1:0] user);
        chk({tag, ".rvalid"}, 64'(s_if.rvalid), 64'(1));
        chk({tag, ".rdata"},  64'(s_if.rdata),  64'(d));
        chk({tag, ".rid"},    64'(s_if.rid),    64'(id));
        chk({tag, ".rresp"},  64'(s_if.rresp),  64'(resp));
        chk({tag, ".rlast"},  64'(s_if.rlast),  64'(last));
        chk({tag, ".ruser"},  64'(s_if.ruser),  64'(user));
    endtask

    logic [31:0] il_d    [4];
    logic [3:0]  il_id   [4];
    logic [1:0]  il_resp [4];
    logic        il_last [4];

    initial begin
        // ---- reset, idle ----
        rst_n = 1'b0;
        s_if.rready = 1'b0;
        put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        chk("rst.m_rready", 64'(m_if.rready), 64'(0));
        chk("rst.s_rvalid", 64'(s_if.rvalid), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.m_rready", 64'(m_if.rready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("idle.s_rvalid", 64'(s_if.rvalid), 64'(0));
            @(negedge clk);
        end

        // ---- streaming burst of 8, RID 3 ----
        s_if.rready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk_head("stream", 32'(i - 1), 4'h3, RRESP_OKAY, (i - 1) == 7, 2'b01);
                chk("stream.m_rready", 64'(m_if.rready), 64'(1));
            end
            if (i < 8) put(1'b1, 32'(i), 4'h3, RRESP_OKAY, i == 7, 2'b01);
            else       put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
            @(negedge clk);
        end
        chk("stream.drain", 64'(s_if.rvalid), 64'(0));

        // ---- back-pressure ----
        s_if.rready = 1'b0;
        put(1'b1, 32'hA0, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        @(negedge clk);
        chk("bp.rdy1", 64'(m_if.rready), 64'(1));
        chk_head("bp.headA", 32'hA0, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        put(1'b1, 32'hB1, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        @(negedge clk);
        chk("bp.full", 64'(m_if.rready), 64'(0));
        chk_head("bp.holdA", 32'hA0, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        put(1'b1, 32'hC2, 4'h5, RRESP_OKAY, 1'b1, 2'b00);
        @(negedge clk);
        chk("bp.stillfull", 64'(m_if.rready), 64'(0));
        chk_head("bp.holdA2", 32'hA0, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        s_if.rready = 1'b1;
        @(negedge clk);
        chk("bp.rdyback", 64'(m_if.rready), 64'(1));
        chk_head("bp.headB", 32'hB1, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        s_if.rready = 1'b0;
        @(negedge clk);
        chk("bp.fullC", 64'(m_if.rready), 64'(0));
        chk_head("bp.holdB", 32'hB1, 4'h5, RRESP_OKAY, 1'b0, 2'b00);
        s_if.rready = 1'b1;
        put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
        @(negedge clk);
        chk_head("bp.headC", 32'hC2, 4'h5, RRESP_OKAY, 1'b1, 2'b00);
        chk("bp.rdyC", 64'(m_if.rready), 64'(1));
        @(negedge clk);
        chk("bp.empty", 64'(s_if.rvalid), 64'(0));

        // ---- simultaneous push/pop at count 1 ----
        s_if.rready = 1'b0;
        put(1'b1, 32'h100, 4'h7, RRESP_OKAY, 1'b0, 2'b11);
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            chk_head("pp", 32'h100 + 32'(k - 1), 4'h7, RRESP_OKAY, 1'b0, 2'b11);
            chk("pp.m_rready", 64'(m_if.rready), 64'(1));
`ifdef AXI4_RDCH_BUF_LEVEL_EN
            chk("pp.level", 64'(rd_fill_level), 64'(1));
`endif
            s_if.rready = 1'b1;
            put(1'b1, 32'h100 + 32'(k), 4'h7, RRESP_OKAY, 1'b0, 2'b11);
            @(negedge clk);
        end
        chk_head("pp.last", 32'h114, 4'h7, RRESP_OKAY, 1'b0, 2'b11);
        put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
        @(negedge clk);
        chk("pp.empty", 64'(s_if.rvalid), 64'(0));
`ifdef AXI4_RDCH_BUF_LEVEL_EN
        chk("pp.level0", 64'(rd_fill_level), 64'(0));
`endif

        // ---- interleaved RIDs, SLVERR on one beat, ruser 2'b10 ----
        il_d[0] = 32'h11; il_id[0] = 4'h1; il_resp[0] = RRESP_OKAY;   il_last[0] = 1'b0;
        il_d[1] = 32'h22; il_id[1] = 4'h2; il_resp[1] = RRESP_SLVERR; il_last[1] = 1'b0;
        il_d[2] = 32'h33; il_id[2] = 4'h1; il_resp[2] = RRESP_OKAY;   il_last[2] = 1'b1;
        il_d[3] = 32'h44; il_id[3] = 4'h2; il_resp[3] = RRESP_EXOKAY; il_last[3] = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) chk_head("il", il_d[i-1], il_id[i-1], il_resp[i-1], il_last[i-1], 2'b10);
            if (i < 4) put(1'b1, il_d[i], il_id[i], il_resp[i], il_last[i], 2'b10);
            else       put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
            @(negedge clk);
        end
        chk("il.empty", 64'(s_if.rvalid), 64'(0));

        // ---- reset with two beats buffered ----
        s_if.rready = 1'b0;
        put(1'b1, 32'hD0, 4'h9, RRESP_OKAY, 1'b0, 2'b00);
        @(negedge clk);
        put(1'b1, 32'hD1, 4'h9, RRESP_OKAY, 1'b1, 2'b00);
        @(negedge clk);
        put(1'b0, 32'h0, 4'h0, RRESP_OKAY, 1'b0, 2'b00);
        chk("mr.full", 64'(m_if.rready), 64'(0));
        chk("mr.valid", 64'(s_if.rvalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mr.async_rvalid", 64'(s_if.rvalid), 64'(0));
        chk("mr.async_rready", 64'(m_if.rready), 64'(0));
`ifdef AXI4_RDCH_BUF_LEVEL_EN
        chk("mr.level", 64'(rd_fill_level), 64'(0));
`endif
        @(negedge clk);
        s_if.rready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr.post_rvalid", 64'(s_if.rvalid), 64'(0));
        chk("mr.post_rready", 64'(m_if.rready), 64'(1));
        @(negedge clk);
        chk("mr.post_empty", 64'(s_if.rvalid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
